// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 5-stage MIPS core.
// Decodes the ID-stage opcode into the 9-bit control bundle
// {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[1:0]}
// and carries it, with the destination register, through ID/EX, EX/MEM and
// MEM/WB. Also handles load-use stalls, branch-flush bubbles, the MEM-stage
// ready handshake and a saturating stall counter.
//
// Optional feature macro: CTRL_PIPE_EXT_OPS_EN (adds addi and j decode,
// drives id_jump). When undefined, addi/j decode as NOP and id_jump is 0.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   id_valid, id_opcode    ID-stage instruction valid / opcode
//   id_rs, id_rt, id_rd    ID-stage register fields
//   flush                  kill the ID-stage instruction
//   mem_ready              memory completes the MEM-stage access this cycle
//   stall_if               hold PC and IF/ID (combinational)
//   id_jump                ID-stage jump decoded (combinational)
//   ex_ctrl                {RegDst, ALUSrc, ALUOp} of ID/EX
//   mem_ctrl               {Branch, MemRead, MemWrite} of EX/MEM
//   wb_ctrl                {RegWrite, MemtoReg} of MEM/WB
//   ex_dst/mem_dst/wb_dst  destination register per stage
//   mem_req                MemRead | MemWrite of EX/MEM
//   stall_count            saturating count of cycles with stall_if=1
module ctrl_pipe #(
   parameter int unsigned RW    = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [RW-1:0]    id_rs,
   input  logic [RW-1:0]    id_rt,
   input  logic [RW-1:0]    id_rd,
   input  logic             flush,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             id_jump,
   output logic [3:0]       ex_ctrl,
   output logic [2:0]       mem_ctrl,
   output logic [1:0]       wb_ctrl,
   output logic [RW-1:0]    ex_dst,
   output logic [RW-1:0]    mem_dst,
   output logic [RW-1:0]    wb_dst,
   output logic             mem_req,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CTRL_PIPE_EXT_OPS_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   // Pipeline state
   logic [8:0]       idex_ctrl_q,  idex_ctrl_d;
   logic [RW-1:0]    idex_dst_q,   idex_dst_d;
   logic [4:0]       exmem_ctrl_q, exmem_ctrl_d;   // {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
   logic [RW-1:0]    exmem_dst_q,  exmem_dst_d;
   logic [1:0]       memwb_ctrl_q, memwb_ctrl_d;
   logic [RW-1:0]    memwb_dst_q,  memwb_dst_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;

   logic [8:0]    id_bundle;
   logic          id_uses_rt;
   logic [RW-1:0] id_dst;
   logic          load_use;
   logic          freeze;

   // ID-stage decode
   always_comb begin
      id_bundle  = '0;
      id_uses_rt = 1'b0;
      id_jump    = 1'b0;
      if (id_valid) begin
         case (id_opcode)
            OP_RTYPE: begin
               id_bundle  = 9'b1_0_000_1_0_10;
               id_uses_rt = 1'b1;
            end
            OP_LW:  id_bundle = 9'b1_1_010_0_1_00;
            OP_SW: begin
               id_bundle  = 9'b0_0_001_0_1_00;
               id_uses_rt = 1'b1;
            end
            OP_BEQ: begin
               id_bundle  = 9'b0_0_100_0_0_01;
               id_uses_rt = 1'b1;
            end
`ifdef CTRL_PIPE_EXT_OPS_EN
            OP_ADDI: id_bundle = 9'b1_0_000_0_1_00;
            OP_J:    id_jump   = ~flush;
`endif
            default: ;
         endcase
      end
   end

   assign id_dst = id_bundle[8] ? (id_bundle[3] ? id_rd : id_rt) : '0;

   assign load_use = id_valid && idex_ctrl_q[5] && (idex_dst_q != '0) &&
                     ((idex_dst_q == id_rs) || (id_uses_rt && (idex_dst_q == id_rt)));

   assign mem_req  = exmem_ctrl_q[1] | exmem_ctrl_q[0];
   assign freeze   = mem_req & ~mem_ready;
   // A flushed instruction is dead, so it cannot cause a load-use stall.
   assign stall_if = freeze | (load_use & ~flush);

   always_comb begin
      idex_ctrl_d  = idex_ctrl_q;
      idex_dst_d   = idex_dst_q;
      exmem_ctrl_d = exmem_ctrl_q;
      exmem_dst_d  = exmem_dst_q;
      memwb_ctrl_d = memwb_ctrl_q;
      memwb_dst_d  = memwb_dst_q;
      if (!freeze) begin
         if (flush || load_use) begin
            idex_ctrl_d = '0;
            idex_dst_d  = '0;
         end else begin
            idex_ctrl_d = id_bundle;
            idex_dst_d  = id_dst;
         end
         exmem_ctrl_d = idex_ctrl_q[8:4];
         exmem_dst_d  = idex_dst_q;
         memwb_ctrl_d = exmem_ctrl_q[4:3];
         memwb_dst_d  = exmem_dst_q;
      end
      cnt_d = cnt_q;
      if (stall_if && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_ctrl_q  <= '0;
         idex_dst_q   <= '0;
         exmem_ctrl_q <= '0;
         exmem_dst_q  <= '0;
         memwb_ctrl_q <= '0;
         memwb_dst_q  <= '0;
         cnt_q        <= '0;
      end else begin
         idex_ctrl_q  <= idex_ctrl_d;
         idex_dst_q   <= idex_dst_d;
         exmem_ctrl_q <= exmem_ctrl_d;
         exmem_dst_q  <= exmem_dst_d;
         memwb_ctrl_q <= memwb_ctrl_d;
         memwb_dst_q  <= memwb_dst_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_ctrl     = idex_ctrl_q[3:0];
   assign ex_dst      = idex_dst_q;
   assign mem_ctrl    = exmem_ctrl_q[2:0];
   assign mem_dst     = exmem_dst_q;
   assign wb_ctrl     = memwb_ctrl_q;
   assign wb_dst      = memwb_dst_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: table-driven decode/latency vectors checked
// through a per-stage scoreboard, plus hand-written multi-cycle sequences
// for load-use, memory freeze, flush and counter saturation/reset.
module tb_ctrl_pipe;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
`ifdef CTRL_PIPE_EXT_OPS_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, id_valid, flush, mem_ready;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt, id_rd;

   logic        stall_if, id_jump, mem_req;
   logic [3:0]  ex_ctrl;
   logic [2:0]  mem_ctrl;
   logic [1:0]  wb_ctrl;
   logic [4:0]  ex_dst, mem_dst, wb_dst;
   logic [15:0] stall_count;

   logic       s_stall_if, s_id_jump, s_mem_req;
   logic [3:0] s_ex_ctrl;
   logic [2:0] s_mem_ctrl;
   logic [1:0] s_wb_ctrl;
   logic [4:0] s_ex_dst, s_mem_dst, s_wb_dst;
   logic [1:0] s_stall_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ctrl_pipe #(.RW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .mem_ready(mem_ready), .stall_if(stall_if), .id_jump(id_jump),
      .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
      .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
      .mem_req(mem_req), .stall_count(stall_count)
   );

   // Narrow counter instance, same stimulus, for saturation
   ctrl_pipe #(.RW(5), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .mem_ready(mem_ready), .stall_if(s_stall_if), .id_jump(s_id_jump),
      .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
      .ex_dst(s_ex_dst), .mem_dst(s_mem_dst), .wb_dst(s_wb_dst),
      .mem_req(s_mem_req), .stall_count(s_stall_count)
   );

   typedef struct {
      logic       v;
      logic [5:0] op;
      logic [4:0] rs, rt, rd;
      logic [3:0] ex;
      logic [4:0] dst;
      logic [2:0] mem;
      logic [1:0] wb;
      logic       jmp;
   } vec_t;

   typedef struct {
      logic [3:0] ex;
      logic [2:0] mem;
      logic [1:0] wb;
      logic [4:0] dst;
   } exp_t;

   vec_t vt[10];
   exp_t ex_q[$], mem_q[$], wb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, input logic mr);
      id_valid  = v;
      id_opcode = op;
      id_rs     = rs;
      id_rt     = rt;
      id_rd     = rd;
      flush     = fl;
      mem_ready = mr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ex_ctrl"},     32'(ex_ctrl), 0);
      chk({tag, " ex_dst"},      32'(ex_dst), 0);
      chk({tag, " mem_ctrl"},    32'(mem_ctrl), 0);
      chk({tag, " mem_dst"},     32'(mem_dst), 0);
      chk({tag, " mem_req"},     32'(mem_req), 0);
      chk({tag, " wb_ctrl"},     32'(wb_ctrl), 0);
      chk({tag, " wb_dst"},      32'(wb_dst), 0);
      chk({tag, " stall_count"}, 32'(stall_count), 0);
      chk({tag, " s_ex"},        32'({s_ex_ctrl, s_ex_dst}), 0);
      chk({tag, " s_mem"},       32'({s_mem_ctrl, s_mem_dst, s_mem_req}), 0);
      chk({tag, " s_wb"},        32'({s_wb_ctrl, s_wb_dst}), 0);
      chk({tag, " s_count"},     32'(s_stall_count), 0);
   endtask

   task automatic do_reset();
      drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      chk_zero("reset");
      #1 chk("reset stall_if", 32'(stall_if), 0);
      chk("reset id_jump", 32'({id_jump, s_id_jump, s_stall_if}), 0);
      reset = 1'b0;
   endtask

   initial begin
      exp_t e;
      vt[0] = '{1'b1, RT,    5'd1, 5'd2,  5'd3,  4'b1010, 5'd3,  3'b000, 2'b10, 1'b0};
      vt[1] = '{1'b1, LW,    5'd1, 5'd5,  5'd7,  4'b0100, 5'd5,  3'b010, 2'b11, 1'b0};
      vt[2] = '{1'b1, SW,    5'd2, 5'd4,  5'd9,  4'b0100, 5'd0,  3'b001, 2'b00, 1'b0};
      vt[3] = '{1'b1, BEQ,   5'd6, 5'd7,  5'd8,  4'b0001, 5'd0,  3'b100, 2'b00, 1'b0};
      vt[4] = '{1'b0, RT,    5'd1, 5'd2,  5'd9,  4'b0000, 5'd0,  3'b000, 2'b00, 1'b0};
      vt[5] = '{1'b1, 6'h3f, 5'd1, 5'd2,  5'd3,  4'b0000, 5'd0,  3'b000, 2'b00, 1'b0};
      vt[6] = '{1'b1, ADDI,  5'd1, 5'd10, 5'd11, EXT ? 4'b0100 : 4'b0000,
                EXT ? 5'd10 : 5'd0, 3'b000, EXT ? 2'b10 : 2'b00, 1'b0};
      vt[7] = '{1'b1, JMP,   5'd1, 5'd2,  5'd3,  4'b0000, 5'd0,  3'b000, 2'b00, EXT};
      vt[8] = '{1'b1, RT,    5'd1, 5'd2,  5'd0,  4'b1010, 5'd0,  3'b000, 2'b10, 1'b0};
      vt[9] = '{1'b1, LW,    5'd3, 5'd12, 5'd0,  4'b0100, 5'd12, 3'b010, 2'b11, 1'b0};

      reset = 1'b1;
      drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      do_reset();

      // ---- table: decode + per-stage latency through the scoreboard ----
      for (int i = 0; i < 13; i++) begin
         if (i < 10) begin
            drive(vt[i].v, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, 1'b0, 1'b1);
            e = '{vt[i].ex, vt[i].mem, vt[i].wb, vt[i].dst};
         end else begin
            drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            e = '{4'b0, 3'b0, 2'b0, 5'd0};
         end
         #1;
         chk($sformatf("v%0d id_jump", i), 32'(id_jump), (i < 10) ? 32'(vt[i].jmp) : 0);
         chk($sformatf("v%0d stall_if", i), 32'(stall_if), 0);
         ex_q.push_back(e);
         tick();
         if (wb_q.size() > 0) begin
            e = wb_q.pop_front();
            chk($sformatf("v%0d wb_ctrl", i), 32'(wb_ctrl), 32'(e.wb));
            chk($sformatf("v%0d wb_dst", i),  32'(wb_dst),  32'(e.dst));
         end
         if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            chk($sformatf("v%0d mem_ctrl", i), 32'(mem_ctrl), 32'(e.mem));
            chk($sformatf("v%0d mem_dst", i),  32'(mem_dst),  32'(e.dst));
            chk($sformatf("v%0d mem_req", i),  32'(mem_req),  32'(e.mem[1] | e.mem[0]));
            wb_q.push_back(e);
         end
         e = ex_q.pop_front();
         chk($sformatf("v%0d ex_ctrl", i), 32'(ex_ctrl), 32'(e.ex));
         chk($sformatf("v%0d ex_dst", i),  32'(ex_dst),  32'(e.dst));
         mem_q.push_back(e);
      end
      chk("table stall_count", 32'(stall_count), 0);

      // ---- load-use ----
      do_reset();
      drive(1'b1, LW, 5'd1, 5'd5, 5'd7, 1'b0, 1'b1);
      tick();
      drive(1'b1, RT, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1);
      #1 chk("lu stall_if", 32'(stall_if), 1);
      tick();
      chk("lu bubble ex_ctrl", 32'(ex_ctrl), 0);
      chk("lu bubble ex_dst", 32'(ex_dst), 0);
      chk("lu lw mem_ctrl", 32'(mem_ctrl), 32'(3'b010));
      chk("lu lw mem_dst", 32'(mem_dst), 5);
      chk("lu count", 32'(stall_count), 1);
      #1 chk("lu stall clear", 32'(stall_if), 0);
      tick();
      chk("lu r ex_ctrl", 32'(ex_ctrl), 32'(4'b1010));
      chk("lu r ex_dst", 32'(ex_dst), 6);
      chk("lu count hold", 32'(stall_count), 1);
      // rt dependency through sw
      drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, SW, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
      #1 chk("lu sw rt stall", 32'(stall_if), 1);
      tick();
      chk("lu sw count", 32'(stall_count), 2);
      // lw does not read rt, so a matching rt is no hazard
      drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, LW, 5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
      #1 chk("lu lw rt no stall", 32'(stall_if), 0);
      tick();
      // load into r0 never stalls
      drive(1'b1, LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, RT, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
      #1 chk("lu r0 no stall", 32'(stall_if), 0);
      tick();
      chk("lu r0 ex_ctrl", 32'(ex_ctrl), 32'(4'b1010));
      chk("lu r0 count", 32'(stall_count), 2);

      // ---- memory freeze ----
      do_reset();
      drive(1'b1, SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, RT, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      tick();
      chk("fz sw mem_req", 32'(mem_req), 1);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, LW, 5'd7, 5'd8, 5'd0, (k == 3), 1'b0);
         #1 chk($sformatf("fz%0d stall_if", k), 32'(stall_if), 1);
         tick();
         chk($sformatf("fz%0d ex", k),  32'({ex_ctrl, ex_dst}), 32'({4'b1010, 5'd3}));
         chk($sformatf("fz%0d mem", k), 32'({mem_ctrl, mem_dst, mem_req}), 32'({3'b001, 5'd0, 1'b1}));
         chk($sformatf("fz%0d wb", k),  32'({wb_ctrl, wb_dst}), 0);
         chk($sformatf("fz%0d count", k), 32'(stall_count), k);
      end
      drive(1'b1, LW, 5'd7, 5'd8, 5'd0, 1'b0, 1'b1);
      #1 chk("fz release stall_if", 32'(stall_if), 0);
      tick();
      chk("fz adv ex", 32'({ex_ctrl, ex_dst}), 32'({4'b0100, 5'd8}));
      chk("fz adv mem", 32'({mem_ctrl, mem_dst, mem_req}), 32'({3'b000, 5'd3, 1'b0}));
      chk("fz adv wb", 32'({wb_ctrl, wb_dst}), 0);
      chk("fz adv count", 32'(stall_count), 3);

      // ---- flush, alone and with load-use ----
      do_reset();
      drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, RT, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1);
      #1 chk("fl+lu stall_if", 32'(stall_if), 0);
      chk("fl jump", 32'(id_jump), 0);
      tick();
      chk("fl+lu ex", 32'({ex_ctrl, ex_dst}), 0);
      chk("fl+lu mem_ctrl", 32'(mem_ctrl), 32'(3'b010));
      chk("fl+lu count", 32'(stall_count), 0);
      drive(1'b1, JMP, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
      #1 chk("fl j id_jump", 32'(id_jump), 0);
      drive(1'b1, RT, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
      tick();
      chk("fl ex", 32'({ex_ctrl, ex_dst}), 0);

      // ---- counter saturation, then reset mid-freeze ----
      do_reset();
      drive(1'b1, SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, RT, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      tick();
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, LW, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0);
         #1 chk($sformatf("sat%0d stall_if", k), 32'(s_stall_if), 1);
         tick();
      end
      chk("sat narrow count", 32'(s_stall_count), 3);
      chk("sat wide count", 32'(stall_count), 5);
      chk("sat held mem_req", 32'(mem_req), 1);
      reset = 1'b1;
      tick();
      chk_zero("midrst");
      reset = 1'b0;
      #1 chk("midrst stall_if", 32'(stall_if), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipelined control unit for the 5-stage MIPS core. Decodes the ID-stage opcode into the 9-bit WB/M/EX control bundle, then carries that bundle and the destination register through the ID/EX, EX/MEM and MEM/WB registers. It also owns load-use hazard detection, branch-flush bubble insertion, the memory-stage ready handshake and a saturating stall counter.

## Interface
- RW, 5: register-index width.
- CNT_W, 16: stall-counter width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID-stage instruction is valid. When low, the ID stage decodes as a NOP.
- id_opcode  in  6  ID-stage opcode.
- id_rs, id_rt, id_rd  in  RW each  ID-stage register fields.
- flush  in  1  kill the ID-stage instruction (branch taken).
- mem_ready  in  1  memory accepts/completes the MEM-stage access this cycle.
- stall_if  out  1  hold PC and IF/ID (combinational).
- id_jump  out  1  ID-stage jump decoded (combinational; only with the macro).
- ex_ctrl  out  4  {RegDst, ALUSrc, ALUOp[1:0]} of the ID/EX register.
- mem_ctrl  out  3  {Branch, MemRead, MemWrite} of the EX/MEM register.
- wb_ctrl  out  2  {RegWrite, MemtoReg} of the MEM/WB register.
- ex_dst, mem_dst, wb_dst  out  RW each  destination register per stage.
- mem_req  out  1  MemRead|MemWrite of EX/MEM.
- stall_count  out  CNT_W  cycles with stall_if=1.

## Operation
- **Decode** (combinational), 9-bit bundle as {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp}. No don't-cares: every unused bit is 0.
  - 000000 R-type → 1_0_000_1_0_10
  - 100011 lw → 1_1_010_0_1_00
  - 101011 sw → 0_0_001_0_1_00
  - 000100 beq → 0_0_100_0_0_01
  - any other opcode, or id_valid=0 → all zeros (NOP).
- **Destination register:** rd if RegDst, else rt. Forced to 0 when RegWrite=0.
- **Load-use hazard:**
  - Condition: ID/EX MemRead=1, ex_dst≠0, and ex_dst equals id_rs, or equals id_rt when the ID instruction uses rt as a source (R-type, sw, beq).
  - Response: stall_if=1; ID/EX loads a bubble; EX/MEM and MEM/WB advance.
- **Flush:** ID/EX loads a bubble; stall_if=0.
- **Memory freeze:**
  - Condition: mem_req=1 and mem_ready=0.
  - Response: all three pipeline registers hold; stall_if=1.
- **Priority, per cycle:** reset > memory freeze > flush > load-use > normal advance.
  - flush together with load-use gives a bubble with stall_if=0, because the ID instruction is dead.
  - flush during a freeze is ignored; the source must hold flush until the freeze ends.
- **Stall counter:** stall_count increments by 1 on every cycle with stall_if=1 and saturates at 2^CNT_W−1. It is never cleared except by reset.

## Timing
- Reset: all control, dst and counter outputs are 0 from the first edge with reset=1. stall_if=0, mem_req=0, id_jump=0. Reset applied mid-operation discards every in-flight bundle.
- Latency from the ID-stage edge:
  - ex_ctrl/ex_dst valid 1 cycle later.
  - mem_ctrl/mem_dst/mem_req valid 2 cycles later.
  - wb_ctrl/wb_dst valid 3 cycles later.
  - Each freeze cycle adds one cycle.
- Load-use stall lasts exactly 1 cycle per hazard. On the next cycle the lw has moved to EX/MEM, so the condition is clear.
- mem_ready is sampled only while mem_req=1. The bundle leaves EX/MEM on the first edge with mem_ready=1.
- stall_if and id_jump are combinational from current inputs and state; no registered delay.

## Configuration
- CTRL_PIPE_EXT_OPS_EN defined:
  - Adds 001000 addi → 1_0_000_0_1_00.
  - Adds 000010 j → all-zero bundle with id_jump=1 (while id_valid=1 and flush=0).
  - addi uses only rs as a source for hazard checks.
- Not defined: addi and j decode as NOP, and id_jump is tied to 0.

## Test plan
- Reset, then R-type (rd=3) held one cycle with id_valid=1:
  - ex_ctrl=4'b1010, ex_dst=3 at +1.
  - mem_ctrl=000 at +2.
  - wb_ctrl=2'b10, wb_dst=3 at +3.
- lw rt=5, then R-type with rs=5: stall_if=1 for exactly 1 cycle, ex_ctrl=0 bubble, stall_count=1. Repeat with rs=0: no stall.
- sw in MEM with mem_ready=0 for 3 cycles: all outputs frozen, stall_if=1 for 3 cycles, stall_count=3. Advance on mem_ready=1.
- flush and load-use in the same cycle: bubble in ID/EX, stall_if=0, stall_count unchanged.
- CNT_W=2, 5 stall cycles: stall_count sticks at 3. Assert reset mid-freeze: everything is 0 on the next edge.
- Macro on: addi → ex_ctrl=4'b0100, wb_ctrl=2'b10; j → id_jump=1 with an all-zero bundle. Macro off: both decode as NOP, id_jump=0.
